fetch_sequencer: RTL

- Program-counter and fetch controller for the 9-bit-instruction core.
- Drives the address into the combinational instruction ROM and sequences execution from a start pulse through to the halt instruction.
- Applies stalls and absolute/relative branches, and reports done plus an elapsed-cycle count to the testbench/top level.

---
 rtl/fetch_sequencer_if.sv | 29 ++
 rtl/fetch_sequencer.sv | 92 +++++++++
 2 files changed

// File: rtl/fetch_sequencer_if.sv
// Fetch-side bundle between the sequencer and its core/ROM environment.
// The master modport is the sequencer; the slave modport is the core/ROM side.
interface fetch_sequencer_if #(
    parameter int D    = 12,
    parameter int OFFW = 8,
    parameter int CW   = 16
);
    logic            start;
    logic            stall;
    logic            branch_taken;
    logic            branch_abs;
    logic [D-1:0]    target;
    logic [OFFW-1:0] offset;
    logic [8:0]      machineCode;
    logic [D-1:0]    progCtr;
    logic            instr_valid;
    logic            done;
    logic [CW-1:0]   cycle_count;

    modport master (
        input  start, stall, branch_taken, branch_abs, target, offset, machineCode,
        output progCtr, instr_valid, done, cycle_count
    );

    modport slave (
        output start, stall, branch_taken, branch_abs, target, offset, machineCode,
        input  progCtr, instr_valid, done, cycle_count
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Program counter and fetch controller: IDLE -> RUN -> DONE, with stall,
// halt detection, absolute/relative branches and a saturating RUN-cycle counter.
module fetch_sequencer #(
    parameter int         D          = 12,
    parameter logic [D-1:0] START_ADDR = '0,
    parameter logic [8:0] HALT_CODE  = 9'b111111111,
    parameter int         OFFW       = 8,
    parameter int         CW         = 16
) (
    input  logic                clk,
    input  logic                reset,
    fetch_sequencer_if.master   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [D-1:0]  pc_q, pc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;

    logic          is_halt;
    logic [D-1:0]  off_ext;

    assign is_halt = (bus.machineCode == HALT_CODE);
    // Relative offsets are two's complement; the sum wraps modulo 2**D.
    assign off_ext = {{(D-OFFW){bus.offset[OFFW-1]}}, bus.offset};

    // NOTE: every always_comb target gets a default first so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = RUN;
                    pc_d    = START_ADDR;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                end
            end
            RUN: begin
                if (cnt_q != {CW{1'b1}}) begin
                    cnt_d = cnt_q + CW'(1);
                end
                // Priority: stall > halt > branch > increment.
                if (!bus.stall) begin
                    if (is_halt) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else if (bus.branch_taken) begin
                        pc_d = bus.branch_abs ? bus.target : (pc_q + off_ext);
                    end else begin
                        pc_d = pc_q + D'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign bus.progCtr     = pc_q;
    assign bus.instr_valid = (state_q == RUN);
    assign bus.done        = done_q;
    assign bus.cycle_count = cnt_q;

endmodule
